i32_mul_arbiter: RTL and testbench

I32_MUL_ARBITER -- requirements
Module: i32_mul_arbiter

---
 rtl/i32_mul_arbiter.sv | 113 +++++++++++
 tb/tb_i32_mul_arbiter.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/i32_mul_arbiter.sv
// Round-robin arbiter sharing one external pipelined 32-bit multiplier among NUM_REQ requesters.
// A tag pipeline matched to MUL_LATENCY routes each product back to the requester that issued it.
module i32_mul_arbiter #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned MUL_LATENCY = 4
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ-1:0][31:0]  req_a,
    input  logic [NUM_REQ-1:0][31:0]  req_b,
    output logic [NUM_REQ-1:0]        req_ready,
    output logic [NUM_REQ-1:0]        resp_valid,
    output logic [31:0]               resp_data,
    output logic [31:0]               mul_in1,
    output logic [31:0]               mul_in2,
    output logic                      mul_tstart,
    input  logic [31:0]               mul_out,
    output logic [3:0]                in_flight
);

    localparam int unsigned IDX_W = $clog2(NUM_REQ);

    logic [IDX_W-1:0]                  r_ptr;
    logic [MUL_LATENCY-1:0]            r_tag_v;
    logic [MUL_LATENCY-1:0][IDX_W-1:0] r_tag_idx;
    logic [3:0]                        r_in_flight;

    logic                              w_issue;
    logic [IDX_W-1:0]                  w_grant_idx;
    logic                              w_resp;
    logic [IDX_W-1:0]                  w_resp_idx;

    // First valid requester at or above the pointer, wrapping past NUM_REQ-1.
    always_comb begin
        int unsigned cand;
        w_issue     = 1'b0;
        w_grant_idx = '0;
        cand        = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            cand = 32'(r_ptr) + k;
            if (cand >= NUM_REQ) cand = cand - NUM_REQ;
            if (!w_issue && req_valid[IDX_W'(cand)]) begin
                w_issue     = 1'b1;
                w_grant_idx = IDX_W'(cand);
            end
        end
    end

    always_comb begin
        req_ready  = '0;
        mul_in1    = '0;
        mul_in2    = '0;
        mul_tstart = 1'b0;
        if (w_issue) begin
            req_ready[w_grant_idx] = 1'b1;
            mul_in1                = req_a[w_grant_idx];
            mul_in2                = req_b[w_grant_idx];
            mul_tstart             = 1'b1;
        end
    end

    assign w_resp     = r_tag_v[MUL_LATENCY-1];
    assign w_resp_idx = r_tag_idx[MUL_LATENCY-1];

    always_comb begin
        resp_valid = '0;
        resp_data  = '0;
        if (w_resp) begin
            resp_valid[w_resp_idx] = 1'b1;
            resp_data              = mul_out;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_issue) begin
            if (w_grant_idx == IDX_W'(NUM_REQ - 1)) r_ptr <= '0;
            else                                    r_ptr <= w_grant_idx + 1'b1;
        end
    end

    // Tags shift unconditionally; there is no stall path anywhere in the pipe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_v   <= '0;
            r_tag_idx <= '0;
        end else begin
            r_tag_v[0]   <= w_issue;
            r_tag_idx[0] <= w_grant_idx;
            for (int unsigned s = 1; s < MUL_LATENCY; s++) begin
                r_tag_v[s]   <= r_tag_v[s-1];
                r_tag_idx[s] <= r_tag_idx[s-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_in_flight <= '0;
        end else begin
            case ({w_issue, w_resp})
                2'b10:   r_in_flight <= r_in_flight + 4'd1;
                2'b01:   r_in_flight <= r_in_flight - 4'd1;
                default: r_in_flight <= r_in_flight;
            endcase
        end
    end

    assign in_flight = r_in_flight;

endmodule

// File: tb/tb_i32_mul_arbiter.sv
// Scoreboard bench for i32_mul_arbiter: grants and products are predicted from the round-robin
// rule and plain 64-bit arithmetic, then matched against responses in issue order.
module tb_i32_mul_arbiter;

    localparam int N = 4;
    localparam int L = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [N-1:0]         req_valid;
    logic [N-1:0][31:0]   req_a;
    logic [N-1:0][31:0]   req_b;
    logic [N-1:0]         req_ready;
    logic [N-1:0]         resp_valid;
    logic [31:0]          resp_data;
    logic [31:0]          mul_in1;
    logic [31:0]          mul_in2;
    logic                 mul_tstart;
    logic [31:0]          mul_out;
    logic [3:0]           in_flight;

    i32_mul_arbiter #(.NUM_REQ(N), .MUL_LATENCY(L)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .mul_in1    (mul_in1),
        .mul_in2    (mul_in2),
        .mul_tstart (mul_tstart),
        .mul_out    (mul_out),
        .in_flight  (in_flight)
    );

    always #5 clk = ~clk;

    // External multiplier: idle slots carry junk so an unqualified resp_data shows up.
    logic [31:0] mpipe [L];
    initial for (int i = 0; i < L; i++) mpipe[i] = 32'hA5A5_0000 + 32'(i);
    always @(posedge clk) begin
        mpipe[0] <= mul_tstart ? (mul_in1 * mul_in2) : $urandom;
        for (int i = 1; i < L; i++) mpipe[i] <= mpipe[i-1];
    end
    assign mul_out = mpipe[L-1];

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int          idx;
        logic [31:0] prod;
        int          cyc;
    } exp_t;
    exp_t q[$];

    int n_checks = 0;
    int n_fail   = 0;
    int max_if   = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Issue tracker: predicts the grant, checks the multiplier drive, records the expected response.
    int           ptr = 0;
    int           g;
    int           c;
    logic [N-1:0] expv;
    logic [63:0]  p64;
    exp_t         e;
    always begin
        @(negedge clk);
        #1;
        if (!rst_n) begin
            ptr = 0;
        end else begin
            g = -1;
            for (int k = 0; k < N; k++) begin
                c = (ptr + k) % N;
                if (g < 0 && req_valid[c]) g = c;
            end
            expv = '0;
            if (g >= 0) expv[g] = 1'b1;
            chk("req_ready", 64'(req_ready), 64'(expv));
            if (g >= 0) begin
                chk("mul_tstart", 64'(mul_tstart), 64'd1);
                chk("mul_in1", 64'(mul_in1), 64'(req_a[g]));
                chk("mul_in2", 64'(mul_in2), 64'(req_b[g]));
                p64    = 64'(req_a[g]) * 64'(req_b[g]);
                e.idx  = g;
                e.prod = p64[31:0];
                e.cyc  = cyc;
                q.push_back(e);
                ptr = (g + 1) % N;
            end else begin
                chk("mul_tstart_idle", 64'(mul_tstart), 64'd0);
                chk("mul_in1_idle", 64'(mul_in1), 64'd0);
                chk("mul_in2_idle", 64'(mul_in2), 64'd0);
            end
        end
    end

    // Response monitor: pops in issue order and checks routing, data and latency.
    exp_t         r;
    logic [N-1:0] rv;
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_resp_valid", 64'(resp_valid), 64'd0);
            chk("rst_resp_data", 64'(resp_data), 64'd0);
            chk("rst_in_flight", 64'(in_flight), 64'd0);
            q.delete();
        end else begin
            chk("in_flight", 64'(in_flight), 64'(q.size()));
            if (int'(in_flight) > max_if) max_if = int'(in_flight);
            if (resp_valid != '0) begin
                if (q.size() == 0) begin
                    chk("resp_unexpected", 64'(resp_valid), 64'd0);
                end else begin
                    r  = q.pop_front();
                    rv = '0;
                    rv[r.idx] = 1'b1;
                    chk("resp_valid", 64'(resp_valid), 64'(rv));
                    chk("resp_data", 64'(resp_data), 64'(r.prod));
                    chk("resp_latency", 64'(cyc - r.cyc), 64'(L));
                end
            end else begin
                chk("resp_data_idle", 64'(resp_data), 64'd0);
                if (q.size() > 0 && q[0].cyc + L <= cyc) begin
                    r  = q.pop_front();
                    rv = '0;
                    rv[r.idx] = 1'b1;
                    chk("resp_missing", 64'(resp_valid), 64'(rv));
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        req_valid = '0;
        repeat (n) tick();
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            req_a[i] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
            req_b[i] = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF : $urandom;
        end
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        repeat (3) @(posedge clk);
        #3 rst_n = 1'b1;
        tick();

        // Single request: 3*5 on requester 0.
        req_a[0] = 32'd3;
        req_b[0] = 32'd5;
        req_valid = 4'b0001;
        tick();
        idle(L + 2);

        // Bring the pointer back to 0, then full contention for 8 cycles.
        req_valid = 4'b1000;
        tick();
        idle(2);
        req_valid = 4'b1111;
        repeat (8) begin
            rand_ops();
            tick();
        end
        idle(L + 2);

        // Wrap-around: pointer to 3, then 1001 grants 3 then 0.
        req_valid = 4'b0100;
        tick();
        req_valid = 4'b1001;
        rand_ops();
        tick();
        rand_ops();
        tick();
        idle(L + 2);

        // Back-to-back on requester 2, including the 32-bit wrap of the product.
        req_valid = 4'b0100;
        req_a[2]  = 32'd7;
        req_b[2]  = 32'd6;
        tick();
        req_a[2]  = 32'hFFFF_FFFF;
        req_b[2]  = 32'd2;
        tick();
        idle(L + 2);

        // Continuous issue to fill the pipeline.
        req_valid = 4'b1111;
        repeat (12) begin
            rand_ops();
            tick();
        end
        idle(L + 2);

        // Three issues, then reset mid-flight; nothing may come back.
        req_valid = 4'b1111;
        repeat (3) begin
            rand_ops();
            tick();
        end
        req_valid = '0;
        #2 rst_n = 1'b0;
        @(posedge clk);
        #3 rst_n = 1'b1;
        idle(L + 2);
        req_valid = 4'b1111;
        rand_ops();
        tick();
        idle(L + 2);

        // Random traffic.
        repeat (400) begin
            req_valid = N'($urandom);
            rand_ops();
            tick();
        end
        idle(L + 3);

        chk("drain_empty", 64'(q.size()), 64'd0);
        chk("in_flight_peak", 64'(max_if), 64'(L));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
